ika9958_cpuif: RTL and testbench
================================

// Module: ika9958_cpuif
// PURPOSE
//  CPU port front end of the IKA9958: decodes the four V9958 I/O ports (MODE[1:0]) and is the direct upstream
//  feeder of the register file. Turns the CPU byte protocol into register-write strobes, VRAM read/write
//  requests with auto-incrementing address, palette writes, and status-read data; shadows R#14/15/16/17.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth on CSR_n/CSW_n/MODE/CD (>=2)
// PORTS
//  i_XTAL1       in   1   system clock; one clock domain
//  i_RST         in   1   synchronous reset, active-high
//  i_CSR_n       in   1   CPU read strobe (async, synchronised here)
//  i_CSW_n       in   1   CPU write strobe (async, synchronised here)
//  i_MODE        in   2   port select: 0 VRAM data, 1 ctrl/status, 2 palette, 3 indirect reg
//  i_CD          in   8   CPU write data
//  o_CD          out  8   CPU read data;  o_CD_OE out 1  drive enable while synchronised CSR_n low
//  o_REG_WR      out  1   one-cycle register write strobe; o_REG_ADDR out 6; o_REG_DATA out 8
//  o_STAT_SEL    out  4   status reg number (R#15[3:0]); i_STAT_DATA in 8; o_STAT_RD out 1 read-done pulse
//  o_VRAM_REQ    out  1   VRAM request, held until ack; o_VRAM_WE out 1; o_VRAM_ADDR out 17; o_VRAM_WDATA out 8
//  i_VRAM_ACK    in   1   one-cycle ack; i_VRAM_RDATA in 8 valid with ack for reads
//  o_PAL_WR      out  1   palette write pulse; o_PAL_IDX out 4; o_PAL_DATA out 9 {R[2:0],B[2:0],G[2:0]}
//  o_OVERRUN     out  1   one-cycle pulse: VRAM access dropped (queue full)
// BEHAVIOUR
//  Reset: all outputs 0; o_CD=0; first-byte flags, address, shadows R14-R17, prefetch latch, queue cleared.
//  Events: write = synchronised CSW_n rising edge (data/MODE captured at that edge); read-start = CSR_n
//   falling edge; read-end = CSR_n rising edge. Effects are applied the cycle after the detected edge.
//  Port 1 write: flag=0 -> latch byte, flag=1. flag=1 -> flag=0; if CD[7]=1: reg write R#CD[5:0]=latched
//   (o_REG_WR 1 cycle); if CD[7]=0: ADDR[7:0]=latched, ADDR[13:8]=CD[5:0], ADDR[16:14]=R14[2:0];
//   CD[6]=0 -> enqueue prefetch read.
//  Port 1 read: o_CD=i_STAT_DATA sampled at read-start; at read-end o_STAT_RD pulses and port-1 flag clears.
//  Port 0 write: enqueue write(ADDR,CD); ADDR+=1. Port 0 read: o_CD=prefetch latch; at read-end enqueue read
//   at ADDR, ADDR+=1. ADDR increment carries from bit 13 into bits 16:14 and updates R14 shadow; 17-bit wrap
//   0x1FFFF->0x00000.
//  Port 2 write: flag=0 -> latch {R,B}; flag=1 -> o_PAL_WR, IDX=R16[3:0], DATA={latched[6:4],latched[2:0],CD[2:0]},
//   R16[3:0]+=1 mod 16, flag=0. Reg write to R#16 also clears palette flag.
//  Port 3 write: target=R17[5:0]; if target!=17 issue reg write; if R17[7]=0, R17[5:0]+=1 mod 64.
//  Every reg write (any path) to R#14/15/16/17 also updates the matching shadow in the same cycle.
//  VRAM queue: 2 entries (active + 1 skid). o_VRAM_REQ high while active entry valid; on i_VRAM_ACK entry
//   retires, skid promotes next cycle (REQ may stay high). Read ack loads prefetch latch with i_VRAM_RDATA.
//   Enqueue with both full: entry dropped, o_OVERRUN pulses; ADDR still increments. Ack with REQ low ignored.
//  Simultaneous: ack and enqueue in same cycle -> retire first, enqueue accepted. Read and write edges never
//   coexist (CPU protocol); if they do, write wins.
//  i_RST mid-transaction drops REQ next cycle; a late ack after reset is ignored.
//  FSMs: port-1 flag {IDLE,HAVE_BYTE}; palette flag {IDLE,HAVE_RB}; queue {EMPTY,ONE,TWO}.
// STRUCTURE
//  Package ika9958_pkg: port enum (P_VRAM,P_CTRL,P_PAL,P_IND), vram_req_t {we,addr[16:0],wdata}, reg-number
//   constants R14/R15/R16/R17.
//  Sub-module ika9958_cpuif_sync: SYNC_STAGES flop synchroniser + edge detect for CSR_n/CSW_n, data capture.
// TESTING
//  Reset, then port1 writes 0x5A,0x87 -> one o_REG_WR, ADDR=7, DATA=0x5A; no VRAM request.
//  R#14=0x01; port1 0xFF,0x7F; port0 writes 0x11,0x22 -> writes at 0x07FFF,0x08000 (carry), R14 shadow=0x02.
//  Port1 0x00,0x00 (read setup) -> prefetch read @0x04000; ack rdata 0xAB; port0 read returns 0xAB, read @0x04001.
//  R#16=15; port2 0x73,0x05 -> o_PAL_WR IDX=15 DATA=9'b111_011_101; next palette IDX=0.
//  Hold i_VRAM_ACK low, 3 port0 writes -> third gives o_OVERRUN; two acks retire two requests in order.
//  R#17=0x0F; port3 writes 0xAA,0xBB,0xCC -> regs 15,16 written, 17 skipped; R17=0x12; i_RST mid-REQ clears all.

Source files
------------

// File: rtl/ika9958_pkg.sv
// Shared types and constants for the IKA9958 CPU port front end.
package ika9958_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 6;
  localparam int unsigned PAL_W  = 9;

  typedef enum logic [1:0] {
    P_VRAM = 2'd0,
    P_CTRL = 2'd1,
    P_PAL  = 2'd2,
    P_IND  = 2'd3
  } port_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } vram_req_t;

  typedef enum logic {F_IDLE, F_HAVE_BYTE} p1_state_e;
  typedef enum logic {PAL_IDLE, PAL_HAVE_RB} pal_state_e;
  typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_TWO} q_state_e;

  localparam logic [REG_W-1:0] R14 = 6'd14;
  localparam logic [REG_W-1:0] R15 = 6'd15;
  localparam logic [REG_W-1:0] R16 = 6'd16;
  localparam logic [REG_W-1:0] R17 = 6'd17;

endpackage

// File: rtl/ika9958_cpuif_sync.sv
// Synchronises the asynchronous CPU strobes, port select and data bus, and
// detects write / read-start / read-end edges on the synchronised strobes.
module ika9958_cpuif_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csr_n,
  input  logic       csw_n,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  output logic       wr_c,
  output logic       rd_start_c,
  output logic       rd_end_c,
  output logic [1:0] mode_c,
  output logic [7:0] data_c,
  output logic       csr_low
);

  logic [SYNC_STAGES-1:0]       csr_sh;
  logic [SYNC_STAGES-1:0]       csw_sh;
  logic [SYNC_STAGES-1:0][1:0]  mode_sh;
  logic [SYNC_STAGES-1:0][7:0]  data_sh;
  logic                         csr_q;
  logic                         csw_q;
  logic                         csr_s;
  logic                         csw_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_sh  <= '1;
      csw_sh  <= '1;
      mode_sh <= '0;
      data_sh <= '0;
      csr_q   <= 1'b1;
      csw_q   <= 1'b1;
      csr_low <= 1'b0;
    end else begin
      csr_sh  <= {csr_sh[SYNC_STAGES-2:0], csr_n};
      csw_sh  <= {csw_sh[SYNC_STAGES-2:0], csw_n};
      mode_sh <= {mode_sh[SYNC_STAGES-2:0], mode};
      data_sh <= {data_sh[SYNC_STAGES-2:0], data};
      csr_q   <= csr_s;
      csw_q   <= csw_s;
      csr_low <= ~csr_s;
    end
  end

  // Write edge suppresses any read edge seen in the same cycle.
  always_comb begin
    csr_s      = csr_sh[SYNC_STAGES-1];
    csw_s      = csw_sh[SYNC_STAGES-1];
    wr_c       = csw_s & ~csw_q;
    rd_start_c = ~wr_c & ~csr_s & csr_q;
    rd_end_c   = ~wr_c & csr_s & ~csr_q;
    mode_c     = mode_sh[SYNC_STAGES-1];
    data_c     = data_sh[SYNC_STAGES-1];
  end

endmodule

// File: rtl/ika9958_cpuif.sv
// IKA9958 CPU port front end: decodes the four I/O ports into register writes,
// VRAM requests (2-deep queue), palette writes and status reads.
module ika9958_cpuif
  import ika9958_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_XTAL1,
  input  logic              i_RST,
  input  logic              i_CSR_n,
  input  logic              i_CSW_n,
  input  logic [1:0]        i_MODE,
  input  logic [7:0]        i_CD,
  output logic [7:0]        o_CD,
  output logic              o_CD_OE,
  output logic              o_REG_WR,
  output logic [REG_W-1:0]  o_REG_ADDR,
  output logic [7:0]        o_REG_DATA,
  output logic [3:0]        o_STAT_SEL,
  input  logic [7:0]        i_STAT_DATA,
  output logic              o_STAT_RD,
  output logic              o_VRAM_REQ,
  output logic              o_VRAM_WE,
  output logic [ADDR_W-1:0] o_VRAM_ADDR,
  output logic [7:0]        o_VRAM_WDATA,
  input  logic              i_VRAM_ACK,
  input  logic [7:0]        i_VRAM_RDATA,
  output logic              o_PAL_WR,
  output logic [3:0]        o_PAL_IDX,
  output logic [PAL_W-1:0]  o_PAL_DATA,
  output logic              o_OVERRUN
);

  logic       wr_c, rd_start_c, rd_end_c, csr_low;
  logic [1:0] mode_c;
  logic [7:0] data_c;

  ika9958_cpuif_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (i_XTAL1),
    .rst        (i_RST),
    .csr_n      (i_CSR_n),
    .csw_n      (i_CSW_n),
    .mode       (i_MODE),
    .data       (i_CD),
    .wr_c       (wr_c),
    .rd_start_c (rd_start_c),
    .rd_end_c   (rd_end_c),
    .mode_c     (mode_c),
    .data_c     (data_c),
    .csr_low    (csr_low)
  );

  p1_state_e         p1_st, p1_st_nxt;
  pal_state_e        pal_st, pal_st_nxt;
  q_state_e          q_st, q_st_nxt;
  logic [7:0]        p1_latch, p1_latch_nxt;
  logic [7:0]        pal_latch, pal_latch_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [7:0]        r14, r14_nxt, r15, r15_nxt, r16, r16_nxt, r17, r17_nxt;
  logic [7:0]        prefetch, prefetch_nxt;
  vram_req_t         q_act, q_act_nxt, q_skid, q_skid_nxt;
  logic [7:0]        cd_nxt;
  logic              reg_wr_nxt, pal_wr_nxt, stat_rd_nxt, ovr_nxt, req_nxt;
  logic [REG_W-1:0]  reg_addr_nxt;
  logic [7:0]        reg_data_nxt;
  logic [3:0]        pal_idx_nxt;
  logic [PAL_W-1:0]  pal_data_nxt;

  port_e             port;
  logic              ack, enq, addr_inc, rw_do;
  vram_req_t         enq_e;
  logic [REG_W-1:0]  rw_addr;
  logic [7:0]        rw_data;

  always_ff @(posedge i_XTAL1) begin
    if (i_RST) begin
      p1_st      <= F_IDLE;
      pal_st     <= PAL_IDLE;
      q_st       <= Q_EMPTY;
      p1_latch   <= '0;
      pal_latch  <= '0;
      addr       <= '0;
      r14        <= '0;
      r15        <= '0;
      r16        <= '0;
      r17        <= '0;
      prefetch   <= '0;
      q_act      <= '0;
      q_skid     <= '0;
      o_CD       <= '0;
      o_REG_WR   <= 1'b0;
      o_REG_ADDR <= '0;
      o_REG_DATA <= '0;
      o_STAT_RD  <= 1'b0;
      o_VRAM_REQ <= 1'b0;
      o_PAL_WR   <= 1'b0;
      o_PAL_IDX  <= '0;
      o_PAL_DATA <= '0;
      o_OVERRUN  <= 1'b0;
    end else begin
      p1_st      <= p1_st_nxt;
      pal_st     <= pal_st_nxt;
      q_st       <= q_st_nxt;
      p1_latch   <= p1_latch_nxt;
      pal_latch  <= pal_latch_nxt;
      addr       <= addr_nxt;
      r14        <= r14_nxt;
      r15        <= r15_nxt;
      r16        <= r16_nxt;
      r17        <= r17_nxt;
      prefetch   <= prefetch_nxt;
      q_act      <= q_act_nxt;
      q_skid     <= q_skid_nxt;
      o_CD       <= cd_nxt;
      o_REG_WR   <= reg_wr_nxt;
      o_REG_ADDR <= reg_addr_nxt;
      o_REG_DATA <= reg_data_nxt;
      o_STAT_RD  <= stat_rd_nxt;
      o_VRAM_REQ <= req_nxt;
      o_PAL_WR   <= pal_wr_nxt;
      o_PAL_IDX  <= pal_idx_nxt;
      o_PAL_DATA <= pal_data_nxt;
      o_OVERRUN  <= ovr_nxt;
    end
  end

  always_comb begin
    p1_st_nxt     = p1_st;
    pal_st_nxt    = pal_st;
    q_st_nxt      = q_st;
    p1_latch_nxt  = p1_latch;
    pal_latch_nxt = pal_latch;
    addr_nxt      = addr;
    r14_nxt       = r14;
    r15_nxt       = r15;
    r16_nxt       = r16;
    r17_nxt       = r17;
    prefetch_nxt  = prefetch;
    q_act_nxt     = q_act;
    q_skid_nxt    = q_skid;
    cd_nxt        = o_CD;
    reg_wr_nxt    = 1'b0;
    reg_addr_nxt  = o_REG_ADDR;
    reg_data_nxt  = o_REG_DATA;
    stat_rd_nxt   = 1'b0;
    pal_wr_nxt    = 1'b0;
    pal_idx_nxt   = o_PAL_IDX;
    pal_data_nxt  = o_PAL_DATA;
    ovr_nxt       = 1'b0;
    req_nxt       = 1'b0;
    enq           = 1'b0;
    enq_e         = '0;
    addr_inc      = 1'b0;
    rw_do         = 1'b0;
    rw_addr       = '0;
    rw_data       = '0;
    port          = port_e'(mode_c);
    ack           = i_VRAM_ACK & o_VRAM_REQ;

    // CPU port decode
    if (wr_c) begin
      case (port)
        P_VRAM: begin
          enq         = 1'b1;
          enq_e.we    = 1'b1;
          enq_e.addr  = addr;
          enq_e.wdata = data_c;
          addr_inc    = 1'b1;
        end
        P_CTRL: begin
          if (p1_st == F_IDLE) begin
            p1_latch_nxt = data_c;
            p1_st_nxt    = F_HAVE_BYTE;
          end else begin
            p1_st_nxt = F_IDLE;
            if (data_c[7]) begin
              rw_do   = 1'b1;
              rw_addr = data_c[5:0];
              rw_data = p1_latch;
            end else begin
              addr_nxt = {r14[2:0], data_c[5:0], p1_latch};
              if (!data_c[6]) begin
                enq        = 1'b1;
                enq_e.addr = addr_nxt;
                addr_inc   = 1'b1;
              end
            end
          end
        end
        P_PAL: begin
          if (pal_st == PAL_IDLE) begin
            pal_latch_nxt = data_c;
            pal_st_nxt    = PAL_HAVE_RB;
          end else begin
            pal_wr_nxt   = 1'b1;
            pal_idx_nxt  = r16[3:0];
            pal_data_nxt = {pal_latch[6:4], pal_latch[2:0], data_c[2:0]};
            r16_nxt[3:0] = r16[3:0] + 4'd1;
            pal_st_nxt   = PAL_IDLE;
          end
        end
        P_IND: begin
          if (r17[5:0] != R17) begin
            rw_do   = 1'b1;
            rw_addr = r17[5:0];
            rw_data = data_c;
          end
          if (!r17[7]) r17_nxt[5:0] = r17[5:0] + 6'd1;
        end
        default: ;
      endcase
    end else if (rd_start_c) begin
      if (port == P_CTRL)      cd_nxt = i_STAT_DATA;
      else if (port == P_VRAM) cd_nxt = prefetch;
    end else if (rd_end_c) begin
      if (port == P_CTRL) begin
        stat_rd_nxt = 1'b1;
        p1_st_nxt   = F_IDLE;
      end else if (port == P_VRAM) begin
        enq        = 1'b1;
        enq_e.addr = addr;
        addr_inc   = 1'b1;
      end
    end

    // Increment carries into the R14 page bits, so the shadow follows
    if (addr_inc) begin
      addr_nxt     = addr_nxt + ADDR_W'(1);
      r14_nxt[2:0] = addr_nxt[16:14];
    end

    // Register write strobe and shadow update
    if (rw_do) begin
      reg_wr_nxt   = 1'b1;
      reg_addr_nxt = rw_addr;
      reg_data_nxt = rw_data;
      if (rw_addr == R14) r14_nxt = rw_data;
      if (rw_addr == R15) r15_nxt = rw_data;
      if (rw_addr == R16) begin
        r16_nxt    = rw_data;
        pal_st_nxt = PAL_IDLE;
      end
      if (rw_addr == R17) r17_nxt = rw_data;
    end

    // Queue: retire on ack first, then accept the new entry
    if (ack && !q_act.we) prefetch_nxt = i_VRAM_RDATA;
    if (ack) begin
      if (q_st == Q_TWO) begin
        q_act_nxt = q_skid;
        q_st_nxt  = Q_ONE;
      end else begin
        q_st_nxt = Q_EMPTY;
      end
    end
    if (enq) begin
      case (q_st_nxt)
        Q_EMPTY: begin
          q_act_nxt = enq_e;
          q_st_nxt  = Q_ONE;
        end
        Q_ONE: begin
          q_skid_nxt = enq_e;
          q_st_nxt   = Q_TWO;
        end
        default: ovr_nxt = 1'b1;
      endcase
    end
    req_nxt = (q_st_nxt != Q_EMPTY);
  end

  assign o_CD_OE      = csr_low;
  assign o_STAT_SEL   = r15[3:0];
  assign o_VRAM_WE    = q_act.we;
  assign o_VRAM_ADDR  = q_act.addr;
  assign o_VRAM_WDATA = q_act.wdata;

endmodule

// File: tb/tb_ika9958_cpuif.sv
// Scoreboard bench for ika9958_cpuif: directed CPU cycles push expectations,
// independent monitor and VRAM responder processes pop and compare.
module tb_ika9958_cpuif;
  import ika9958_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, csr_n, csw_n;
  logic [1:0]  mode;
  logic [7:0]  cd_in;
  logic [7:0]  cd_out;
  logic        cd_oe, reg_wr, stat_rd, vram_req, vram_we, pal_wr, overrun;
  logic [5:0]  reg_addr;
  logic [7:0]  reg_data, stat_data, vram_wdata, vram_rdata;
  logic [3:0]  stat_sel, pal_idx;
  logic [16:0] vram_addr;
  logic [8:0]  pal_data;
  logic        vram_ack;
  logic        mem_ack = 1'b0, force_ack = 1'b0, ack_en = 1'b1;
  logic [7:0]  mem_rdata = '0, force_rdata = '0;

  assign vram_ack   = mem_ack | force_ack;
  assign vram_rdata = force_ack ? force_rdata : mem_rdata;
  assign stat_data  = {4'hC, stat_sel};

  ika9958_cpuif #(.SYNC_STAGES(2)) dut (
    .i_XTAL1(clk), .i_RST(rst), .i_CSR_n(csr_n), .i_CSW_n(csw_n),
    .i_MODE(mode), .i_CD(cd_in), .o_CD(cd_out), .o_CD_OE(cd_oe),
    .o_REG_WR(reg_wr), .o_REG_ADDR(reg_addr), .o_REG_DATA(reg_data),
    .o_STAT_SEL(stat_sel), .i_STAT_DATA(stat_data), .o_STAT_RD(stat_rd),
    .o_VRAM_REQ(vram_req), .o_VRAM_WE(vram_we), .o_VRAM_ADDR(vram_addr),
    .o_VRAM_WDATA(vram_wdata), .i_VRAM_ACK(vram_ack), .i_VRAM_RDATA(vram_rdata),
    .o_PAL_WR(pal_wr), .o_PAL_IDX(pal_idx), .o_PAL_DATA(pal_data),
    .o_OVERRUN(overrun)
  );

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } vexp_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [13:0] reg_q[$];
  logic [12:0] pal_q[$];
  logic [7:0]  rd_q[$];
  logic [3:0]  stat_q[$];
  logic        ovr_q[$];
  vexp_t       vram_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Output monitor
  initial begin : monitor
    logic prev_oe;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (reg_wr) begin
          check("reg_wr pending", 32'(reg_q.size() != 0), 1);
          if (reg_q.size() != 0) check("reg_wr addr/data", {18'd0, reg_addr, reg_data}, {18'd0, reg_q.pop_front()});
        end
        if (pal_wr) begin
          check("pal_wr pending", 32'(pal_q.size() != 0), 1);
          if (pal_q.size() != 0) check("pal_wr idx/data", {19'd0, pal_idx, pal_data}, {19'd0, pal_q.pop_front()});
        end
        if (stat_rd) begin
          check("stat_rd pending", 32'(stat_q.size() != 0), 1);
          if (stat_q.size() != 0) check("stat_sel", {28'd0, stat_sel}, {28'd0, stat_q.pop_front()});
        end
        if (overrun) begin
          check("overrun pending", 32'(ovr_q.size() != 0), 1);
          if (ovr_q.size() != 0) check("overrun", {31'd0, overrun}, {31'd0, ovr_q.pop_front()});
        end
        if (prev_oe && !cd_oe) begin
          check("read pending", 32'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) check("read data", {24'd0, cd_out}, {24'd0, rd_q.pop_front()});
        end
      end
      prev_oe = cd_oe;
    end
  end

  // VRAM responder: acks one request at a time, comparing each against the scoreboard
  initial begin : responder
    vexp_t e;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (ack_en && !rst && vram_req) begin
        check("vram pending", 32'(vram_q.size() != 0), 1);
        if (vram_q.size() != 0) begin
          e = vram_q.pop_front();
          check("vram req", {6'd0, vram_we, vram_addr, vram_we ? vram_wdata : 8'h00},
                {6'd0, e.we, e.addr, e.we ? e.wdata : 8'h00});
          mem_rdata = e.rdata;
        end
        mem_ack = 1'b1;
      end
    end
  end

  task automatic cpu_wr(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    mode = m; cd_in = d;
    repeat (2) @(negedge clk);
    csw_n = 1'b0;
    repeat (4) @(negedge clk);
    csw_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic cpu_rd(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    repeat (2) @(negedge clk);
    csr_n = 1'b0;
    repeat (6) @(negedge clk);
    csr_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic reg_write(input logic [5:0] r, input logic [7:0] v);
    reg_q.push_back({r, v});
    cpu_wr(2'd1, v);
    cpu_wr(2'd1, {2'b10, r});
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && vram_req; i++) @(negedge clk);
    check(name, {31'd0, vram_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; csr_n = 1'b1; csw_n = 1'b1; mode = 2'd0; cd_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset outputs", {20'd0, vram_req, reg_wr, pal_wr, overrun, stat_rd, cd_oe, stat_sel, 2'b00},
          32'd0);
    check("reset cd/addr", {7'd0, cd_out, vram_addr}, 32'd0);

    // Register write R#7 = 0x5A, no VRAM traffic
    reg_write(6'd7, 8'h5A);

    // Page carry from bit 13 into R14 bits
    reg_write(6'd14, 8'h01);
    cpu_wr(2'd1, 8'hFF); cpu_wr(2'd1, 8'h7F);
    vram_q.push_back('{1'b1, 17'h07FFF, 8'h11, 8'h00});
    cpu_wr(2'd0, 8'h11);
    vram_q.push_back('{1'b1, 17'h08000, 8'h22, 8'h00});
    cpu_wr(2'd0, 8'h22);
    wait_idle("drain after carry");
    // New write setup exposes the R14 shadow (now 2)
    cpu_wr(2'd1, 8'h00); cpu_wr(2'd1, 8'h40);
    vram_q.push_back('{1'b1, 17'h08000, 8'h33, 8'h00});
    cpu_wr(2'd0, 8'h33);
    wait_idle("drain after shadow");

    // Read setup with prefetch, then port-0 read
    reg_write(6'd14, 8'h01);
    vram_q.push_back('{1'b0, 17'h04000, 8'h00, 8'hAB});
    cpu_wr(2'd1, 8'h00); cpu_wr(2'd1, 8'h00);
    wait_idle("drain prefetch");
    rd_q.push_back(8'hAB);
    vram_q.push_back('{1'b0, 17'h04001, 8'h00, 8'h3C});
    cpu_rd(2'd0);
    wait_idle("drain read");

    // Status read of S#5
    reg_write(6'd15, 8'h05);
    rd_q.push_back(8'hC5); stat_q.push_back(4'd5);
    cpu_rd(2'd1);

    // Palette writes with index wrap 15 -> 0
    reg_write(6'd16, 8'h0F);
    pal_q.push_back({4'd15, 9'b111_011_101});
    cpu_wr(2'd2, 8'h73); cpu_wr(2'd2, 8'h05);
    pal_q.push_back({4'd0, 9'b001_010_100});
    cpu_wr(2'd2, 8'h12); cpu_wr(2'd2, 8'h34);

    // Queue overrun with acks held off
    ack_en = 1'b0;
    cpu_wr(2'd1, 8'h00); cpu_wr(2'd1, 8'h40);
    vram_q.push_back('{1'b1, 17'h04000, 8'h01, 8'h00});
    vram_q.push_back('{1'b1, 17'h04001, 8'h02, 8'h00});
    cpu_wr(2'd0, 8'h01); cpu_wr(2'd0, 8'h02);
    ovr_q.push_back(1'b1);
    cpu_wr(2'd0, 8'h03);
    check("req held without ack", {31'd0, vram_req}, 32'd1);
    ack_en = 1'b1;
    wait_idle("drain after overrun");

    // Indirect port: R17 auto-increment, R#17 itself skipped
    reg_write(6'd17, 8'h0F);
    reg_q.push_back({6'd15, 8'hAA}); cpu_wr(2'd3, 8'hAA);
    reg_q.push_back({6'd16, 8'hBB}); cpu_wr(2'd3, 8'hBB);
    cpu_wr(2'd3, 8'hCC);
    reg_q.push_back({6'd18, 8'hDD}); cpu_wr(2'd3, 8'hDD);
    rd_q.push_back(8'hCA); stat_q.push_back(4'hA);
    cpu_rd(2'd1);

    // Reset with a request outstanding, then a stray ack
    ack_en = 1'b0;
    cpu_wr(2'd0, 8'h55);
    check("req before reset", {31'd0, vram_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("req dropped by reset", {31'd0, vram_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    force_rdata = 8'hEE; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("stray ack ignored", {31'd0, vram_req}, 32'd0);
    ack_en = 1'b1;
    rd_q.push_back(8'h00);
    vram_q.push_back('{1'b0, 17'h00000, 8'h00, 8'h99});
    cpu_rd(2'd0);
    wait_idle("drain after reset");

    repeat (10) @(negedge clk);
    check("reg queue empty",  32'(reg_q.size()),  32'd0);
    check("pal queue empty",  32'(pal_q.size()),  32'd0);
    check("read queue empty", 32'(rd_q.size()),   32'd0);
    check("stat queue empty", 32'(stat_q.size()), 32'd0);
    check("ovr queue empty",  32'(ovr_q.size()),  32'd0);
    check("vram queue empty", 32'(vram_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
